cache_write_buffer: RTL and testbench
=====================================

# cache_write_buffer

Posted-write buffer between the direct-mapped data cache and main memory. It absorbs dirty-line write-backs from the cache, acknowledges them quickly and drains them to memory in the background. Cache reads that hit a buffered line are served from the buffer; all other reads go to memory. Upstream it presents the same hold-until-ready 128-bit line protocol the cache already drives; downstream it drives the memory with that same protocol.

## Interface
- DEPTH, 4: number of line entries (power of two, 2..8)
- clk  in  1  clock, all state on rising edge
- proc_reset_n  in  1  asynchronous, active-low reset
- c_read  in  1  cache line-read request, held until c_ready
- c_write  in  1  cache line-write request, held until c_ready
- c_addr  in  28  line address
- c_wdata  in  128  write line data
- c_rdata  out  128  read line data, valid while c_ready=1 after a read
- c_ready  out  1  one-cycle completion pulse to cache
- mem_read  out  1  memory line read, held until mem_ready
- mem_write  out  1  memory line write, held until mem_ready
- mem_addr  out  28  memory line address
- mem_wdata  out  128  memory write data
- mem_rdata  in  128  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle memory completion pulse
- wb_empty  out  1  no entries held and no memory write in flight

## Operation
- Storage: DEPTH entries {valid, addr[27:0], data[127:0]}, circular FIFO with head/tail pointers and an occupancy count (0..DEPTH).
- Upstream FSM: U_IDLE, U_MISS (read waiting on memory), U_ACK (c_ready=1 for exactly one cycle). It returns to U_IDLE after U_ACK.
- A request is sampled only in U_IDLE. If c_read and c_write are both 1, the write is taken.
- Write, address matches a valid entry that is not in flight: overwrite that entry's data. This is allowed even when full. Count unchanged, go to U_ACK.
- Write, no coalescible match, count<DEPTH: enqueue at tail, count+1, go to U_ACK.
- Write, full, no coalescible match: stay in U_IDLE, no ack. Retry every cycle until a drain frees an entry.
- Read, address matches any valid entry (including the in-flight head): c_rdata = data of the youngest matching entry. Go to U_ACK.
- Read miss: go to U_MISS.
- Memory FSM: M_IDLE, M_WRITE, M_READ.
- From M_IDLE, a pending U_MISS read has priority: go to M_READ, mem_read=1, mem_addr=c_addr.
- Otherwise, if count>0: go to M_WRITE with the head entry. mem_write=1, mem_addr/mem_wdata = head. The head entry is marked in flight.
- M_WRITE on mem_ready: pop head, count-1, return to M_IDLE.
- M_READ on mem_ready: register mem_rdata into c_rdata, return to M_IDLE; upstream goes to U_ACK.
- A read miss arriving during M_WRITE waits for that write to finish, then is issued. No further drains start while U_MISS is pending.
- After any mem_ready, mem_read and mem_write are 0 for at least one cycle.
- An in-flight head is never coalesced into. A write to its address enqueues a new entry.

## Timing
- Reset (async, proc_reset_n=0): all entries invalid, count=0, FSMs to U_IDLE/M_IDLE. c_ready=0, c_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, wb_empty=1. Buffered and in-flight writes are discarded.
- All outputs are registered.
- Write accept or read hit: request sampled in cycle T, c_ready=1 in T+1. A new request may be sampled in T+2.
- Read miss, memory idle: sampled T; mem_read=1 from T+1. With mem_ready at cycle R: c_ready=1 and c_rdata valid at R+1, mem_read=0 at R+1.
- Drain: mem_write rises the cycle after M_IDLE sees count>0. It falls the cycle after mem_ready.
- mem_addr and mem_wdata are stable while mem_read or mem_write is 1.
- Pointer wrap: head/tail wrap modulo DEPTH.
- Enqueue and pop in the same cycle: count unchanged.
- wb_empty=1 only when count=0 and the memory FSM is not in M_WRITE.

## Test plan
- Reset then idle: all outputs 0 and wb_empty=1. Write addr 0x10, data A → c_ready at T+1. mem_write with addr 0x10, data A follows; after mem_ready, wb_empty=1.
- Memory stalled, DEPTH=4: write 4 distinct lines, each acked in 2 cycles. A fifth distinct write gets no ack until the first mem_ready, then acks one cycle after the pop.
- Buffer holds 0x20=B, not in flight: write 0x20=C → ack in 1 cycle, count unchanged. Memory later receives C, not B.
- Buffer holds 0x30=D: read 0x30 → c_rdata=D, c_ready at T+1, no mem_read.
- Write to 0x40 in flight with memory latency 5: read 0x50 → mem_read rises only after the write's mem_ready plus one idle cycle. c_rdata = mem_rdata one cycle after the read's mem_ready.
- proc_reset_n pulsed low during M_WRITE with 3 entries: mem_write drops immediately, count=0, wb_empty=1. A following read of a previously buffered address goes to memory.

Source files
------------

// File: rtl/cache_write_buffer.sv
// Posted-write buffer between the direct-mapped data cache and main memory.
// Acks line write-backs early, serves read hits from buffered lines, drains entries in order.
module cache_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         proc_reset_n,
  input  logic         c_read,
  input  logic         c_write,
  input  logic [27:0]  c_addr,
  input  logic [127:0] c_wdata,
  output logic [127:0] c_rdata,
  output logic         c_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic         wb_empty
);

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {U_IDLE, U_MISS, U_ACK} u_state_e;
  typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} m_state_e;

  u_state_e        u_q, u_d;
  m_state_e        m_q, m_d;
  logic            valid_q [DEPTH];
  logic            valid_d [DEPTH];
  logic [AW-1:0]   addr_q  [DEPTH];
  logic [AW-1:0]   addr_d  [DEPTH];
  logic [DW-1:0]   data_q  [DEPTH];
  logic [DW-1:0]   data_d  [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            c_ready_q, c_ready_d;
  logic [DW-1:0]   c_rdata_q, c_rdata_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            wb_empty_q, wb_empty_d;

  logic            hit_c;
  logic [DW-1:0]   hit_data_c;
  logic            co_hit_c;
  logic [PW-1:0]   co_idx_c;
  logic            miss_c;
  logic            head_fwd_c;

  // Address lookup, scanned oldest to youngest so the youngest match wins.
  // The head is excluded from coalescing while its write is on the memory bus.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    hit_c      = 1'b0;
    hit_data_c = '0;
    co_hit_c   = 1'b0;
    co_idx_c   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = PW'(head_q + PW'(k));
      if (valid_q[idx] && (addr_q[idx] == c_addr)) begin
        hit_c      = 1'b1;
        hit_data_c = data_q[idx];
        if (!((m_q == M_WRITE) && (idx == head_q))) begin
          co_hit_c = 1'b1;
          co_idx_c = idx;
        end
      end
    end
  end

  assign miss_c     = (u_q == U_MISS) || ((u_q == U_IDLE) && !c_write && c_read && !hit_c);
  // A write coalescing into the head in the very cycle its drain starts must reach memory.
  assign head_fwd_c = (u_q == U_IDLE) && c_write && co_hit_c && (co_idx_c == head_q);

  always_comb begin
    logic push;
    logic pop;
    push        = 1'b0;
    pop         = 1'b0;
    u_d         = u_q;
    m_d         = m_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    c_ready_d   = 1'b0;
    c_rdata_d   = c_rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (u_q)
      U_IDLE: begin
        if (c_write) begin
          if (co_hit_c) begin
            data_d[co_idx_c] = c_wdata;
            u_d              = U_ACK;
            c_ready_d        = 1'b1;
          end else if (count_q < CW'(DEPTH)) begin
            push      = 1'b1;
            u_d       = U_ACK;
            c_ready_d = 1'b1;
          end
        end else if (c_read) begin
          if (hit_c) begin
            c_rdata_d = hit_data_c;
            u_d       = U_ACK;
            c_ready_d = 1'b1;
          end else begin
            u_d = U_MISS;
          end
        end
      end
      U_MISS: begin
        if ((m_q == M_READ) && mem_ready) begin
          c_rdata_d = mem_rdata;
          u_d       = U_ACK;
          c_ready_d = 1'b1;
        end
      end
      default: u_d = U_IDLE;
    endcase

    // Pending read misses take the memory ahead of any further drain.
    case (m_q)
      M_IDLE: begin
        if (miss_c) begin
          m_d        = M_READ;
          mem_read_d = 1'b1;
          mem_addr_d = c_addr;
        end else if (count_q != '0) begin
          m_d         = M_WRITE;
          mem_write_d = 1'b1;
          mem_addr_d  = addr_q[head_q];
          mem_wdata_d = head_fwd_c ? c_wdata : data_q[head_q];
        end
      end
      M_WRITE: begin
        if (mem_ready) begin
          m_d         = M_IDLE;
          mem_write_d = 1'b0;
          pop         = 1'b1;
        end
      end
      M_READ: begin
        if (mem_ready) begin
          m_d        = M_IDLE;
          mem_read_d = 1'b0;
        end
      end
      default: m_d = M_IDLE;
    endcase

    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = c_addr;
      data_d[tail_q]  = c_wdata;
      tail_d          = PW'(tail_q + PW'(1));
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = PW'(head_q + PW'(1));
    end
    if (push && !pop) begin
      count_d = CW'(count_q + CW'(1));
    end else if (pop && !push) begin
      count_d = CW'(count_q - CW'(1));
    end
    wb_empty_d = (count_d == '0) && (m_d != M_WRITE);
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      u_q         <= U_IDLE;
      m_q         <= M_IDLE;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        addr_q[k]  <= '0;
        data_q[k]  <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      c_ready_q   <= 1'b0;
      c_rdata_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_empty_q  <= 1'b1;
    end else begin
      u_q         <= u_d;
      m_q         <= m_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      c_ready_q   <= c_ready_d;
      c_rdata_q   <= c_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_empty_q  <= wb_empty_d;
    end
  end

  assign c_ready   = c_ready_q;
  assign c_rdata   = c_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_empty  = wb_empty_q;

endmodule

// File: tb/tb_cache_write_buffer.sv
// Bench for cache_write_buffer: directed timing scenarios, then random traffic checked
// against a flat memory image (last acked write per address) and a behavioural memory.
module tb_cache_write_buffer;

  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         c_read, c_write;
  logic [27:0]  c_addr;
  logic [127:0] c_wdata, c_rdata;
  logic         c_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;
  logic         wb_empty;

  cache_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ready(c_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Behavioural memory and its activity log
  logic [127:0] mem_model [logic [27:0]];
  logic [27:0]  wr_log_addr [$];
  logic [127:0] wr_log_data [$];
  int           wr_log_cyc  [$];
  int  mem_lat = 1;
  bit  mem_stall = 1'b0;
  int  proto_viol = 0;
  int  n_rd_issue = 0;
  int  rd_rise_cyc = -1;
  int  last_rd_ready_cyc = -1;

  function automatic logic [127:0] init_val(input logic [27:0] a);
    return {4{4'hC, a}};
  endfunction

  function automatic logic [127:0] mem_peek(input logic [27:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return init_val(a);
  endfunction

  // Memory responder: pulses mem_ready after mem_lat cycles of a held request.
  initial begin : responder
    int           wait_cnt;
    bit           req_prev;
    logic [27:0]  held_addr;
    logic [127:0] held_data;
    wait_cnt  = 0;
    req_prev  = 1'b0;
    held_addr = '0;
    held_data = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        if (mem_read || mem_write) proto_viol++;
        req_prev = 1'b0;
        wait_cnt = 0;
      end else if (mem_read || mem_write) begin
        if (mem_read && mem_write) proto_viol++;
        if (!req_prev) begin
          held_addr = mem_addr;
          held_data = mem_wdata;
          if (mem_read) begin
            n_rd_issue++;
            rd_rise_cyc = cyc;
          end
        end else if ((mem_addr !== held_addr) || (mem_write && (mem_wdata !== held_data))) begin
          proto_viol++;
        end
        req_prev = 1'b1;
        if (!mem_stall) begin
          wait_cnt++;
          if (wait_cnt >= mem_lat) begin
            mem_ready = 1'b1;
            if (mem_write) begin
              mem_model[mem_addr] = mem_wdata;
              wr_log_addr.push_back(mem_addr);
              wr_log_data.push_back(mem_wdata);
              wr_log_cyc.push_back(cyc);
            end else begin
              mem_rdata = mem_peek(mem_addr);
              last_rd_ready_cyc = cyc;
            end
          end
        end
      end else begin
        req_prev = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Issue a write, hold until c_ready (bounded), then leave one idle cycle.
  task automatic do_write(input logic [27:0] a, input logic [127:0] d, input bit also_rd,
                          output int lat, output int ack_cyc);
    c_addr = a; c_wdata = d; c_write = 1'b1; c_read = also_rd;
    lat = -1; ack_cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (c_ready === 1'b1) begin
        lat = i; ack_cyc = cyc;
        break;
      end
    end
    c_write = 1'b0; c_read = 1'b0;
    step();
  endtask

  task automatic do_read(input logic [27:0] a, output int lat, output logic [127:0] data,
                         output int drv_cyc, output int ack_cyc);
    c_addr = a; c_read = 1'b1; c_write = 1'b0;
    drv_cyc = cyc; lat = -1; ack_cyc = -1; data = 'x;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (c_ready === 1'b1) begin
        lat = i; ack_cyc = cyc; data = c_rdata;
        break;
      end
    end
    c_read = 1'b0;
    step();
  endtask

  task automatic wait_empty(output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      if (wb_empty === 1'b1) begin
        at_cyc = cyc;
        break;
      end
      step();
    end
  endtask

  initial begin : main
    int           lat, ack, drv, ec, base, rd0;
    bit           saw;
    logic [127:0] d, rdat;
    logic [127:0] d2 [5];
    logic [27:0]  a;
    logic [127:0] ref_m [logic [27:0]];

    proc_reset_n = 1'b0;
    c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
    repeat (3) step();
    check_b("rst_c_ready", c_ready, 1'b0);
    check("rst_c_rdata", c_rdata, '0);
    check_b("rst_mem_read", mem_read, 1'b0);
    check_b("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", 128'(mem_addr), '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check_b("rst_wb_empty", wb_empty, 1'b1);
    proc_reset_n = 1'b1;
    step(); step();
    check_b("idle_mem_write", mem_write, 1'b0);
    check_b("idle_wb_empty", wb_empty, 1'b1);

    // Single write, then background drain
    mem_lat = 3;
    base = wr_log_addr.size();
    d = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
    do_write(28'h10, d, 1'b0, lat, ack);
    check_int("t1_ack_lat", lat, 1);
    check_b("t1_mem_write", mem_write, 1'b1);
    check("t1_mem_addr", 128'(mem_addr), 128'(28'h10));
    check("t1_mem_wdata", mem_wdata, d);
    check_b("t1_wb_busy", wb_empty, 1'b0);
    wait_empty(ec);
    check_int("t1_log_n", wr_log_addr.size(), base + 1);
    check_int("t1_empty_cyc", ec, wr_log_cyc[base] + 1);
    check("t1_log_data", wr_log_data[base], d);

    // Fill with memory stalled; fifth write waits for the first pop
    mem_stall = 1'b1;
    base = wr_log_addr.size();
    for (int k = 0; k < 5; k++) d2[k] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      do_write(28'h100 + 28'(k), d2[k], 1'b0, lat, ack);
      check_int("t2_fill_lat", lat, 1);
    end
    c_addr = 28'h104; c_wdata = d2[4]; c_write = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      step();
      if (c_ready === 1'b1) saw = 1'b1;
    end
    check_b("t2_no_ack_full", saw, 1'b0);
    mem_lat = 1; mem_stall = 1'b0;
    ack = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (c_ready === 1'b1) begin
        ack = cyc;
        break;
      end
    end
    c_write = 1'b0;
    step();
    wait_empty(ec);
    check_int("t2_log_n", wr_log_addr.size(), base + 5);
    check_int("t2_ack_after_pop", ack, wr_log_cyc[base] + 2);
    for (int k = 0; k < 5; k++) begin
      check("t2_order_addr", 128'(wr_log_addr[base + k]), 128'(28'h100 + 28'(k)));
      check("t2_order_data", wr_log_data[base + k], d2[k]);
    end

    // Coalesce into a buffered, not-in-flight line
    mem_stall = 1'b1;
    base = wr_log_addr.size();
    do_write(28'h1F0, d2[0], 1'b0, lat, ack);
    do_write(28'h20, d2[1], 1'b0, lat, ack);
    do_write(28'h20, d2[2], 1'b0, lat, ack);
    check_int("t3_coalesce_lat", lat, 1);
    mem_stall = 1'b0;
    wait_empty(ec);
    check_int("t3_log_n", wr_log_addr.size(), base + 2);
    check("t3_first_addr", 128'(wr_log_addr[base]), 128'(28'h1F0));
    check("t3_second_addr", 128'(wr_log_addr[base + 1]), 128'(28'h20));
    check("t3_second_data", wr_log_data[base + 1], d2[2]);

    // Read hits: normal entry, in-flight head, youngest of two copies
    mem_stall = 1'b1;
    base = wr_log_addr.size();
    rd0 = n_rd_issue;
    do_write(28'h1F1, d2[3], 1'b0, lat, ack);
    do_write(28'h30, d2[4], 1'b0, lat, ack);
    do_read(28'h30, lat, rdat, drv, ack);
    check_int("t4_hit_lat", lat, 1);
    check("t4_hit_data", rdat, d2[4]);
    do_read(28'h1F1, lat, rdat, drv, ack);
    check("t4_inflight_hit", rdat, d2[3]);
    do_write(28'h1F1, d2[0], 1'b0, lat, ack);
    check_int("t4_noco_lat", lat, 1);
    do_read(28'h1F1, lat, rdat, drv, ack);
    check("t4_youngest", rdat, d2[0]);
    check_int("t4_no_mem_read", n_rd_issue, rd0);
    mem_stall = 1'b0;
    wait_empty(ec);
    check_int("t4_log_n", wr_log_addr.size(), base + 3);
    check("t4_head_data", wr_log_data[base], d2[3]);
    check("t4_tail_data", wr_log_data[base + 2], d2[0]);

    // Read miss behind an in-flight write, then with memory idle
    mem_lat = 5;
    base = wr_log_addr.size();
    do_write(28'h40, d2[1], 1'b0, lat, ack);
    do_read(28'h50, lat, rdat, drv, ack);
    check_int("t5_rd_after_wr", rd_rise_cyc, wr_log_cyc[base] + 2);
    check_int("t5_ack_cyc", ack, last_rd_ready_cyc + 1);
    check("t5_miss_data", rdat, init_val(28'h50));
    wait_empty(ec);
    do_read(28'h60, lat, rdat, drv, ack);
    check_int("t5_idle_rd_rise", rd_rise_cyc, drv + 1);
    check("t5_idle_data", rdat, init_val(28'h60));

    // Reset while draining discards everything
    mem_stall = 1'b1;
    mem_lat = 2;
    base = wr_log_addr.size();
    do_write(28'h70, d2[2], 1'b0, lat, ack);
    do_write(28'h71, d2[3], 1'b0, lat, ack);
    do_write(28'h72, d2[4], 1'b0, lat, ack);
    check_b("t6_draining", mem_write, 1'b1);
    proc_reset_n = 1'b0;
    #1;
    check_b("t6_rst_mem_write", mem_write, 1'b0);
    check_b("t6_rst_wb_empty", wb_empty, 1'b1);
    step(); step();
    proc_reset_n = 1'b1;
    step();
    mem_stall = 1'b0;
    rd0 = n_rd_issue;
    do_read(28'h71, lat, rdat, drv, ack);
    check("t6_read_from_mem", rdat, init_val(28'h71));
    check_int("t6_mem_read_issued", n_rd_issue, rd0 + 1);
    repeat (10) step();
    check_int("t6_nothing_drained", wr_log_addr.size(), base);

    // Random traffic against a flat memory image
    for (int n = 0; n < 300; n++) begin
      mem_lat = int'($urandom_range(1, 4));
      a = 28'h200 + 28'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        do_write(a, d, 1'($urandom_range(0, 1)), lat, ack);
        check_b("rnd_wr_acked", lat > 0, 1'b1);
        if (lat > 0) ref_m[a] = d;
      end else begin
        do_read(a, lat, rdat, drv, ack);
        check("rnd_rd_data", rdat, ref_m.exists(a) ? ref_m[a] : init_val(a));
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) step();
    end
    wait_empty(ec);
    check_b("rnd_drained", ec >= 0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      a = 28'h200 + 28'(k);
      if (ref_m.exists(a)) check("rnd_mem_final", mem_peek(a), ref_m[a]);
    end
    check_int("protocol_violations", proto_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
